// File: rtl/exec_unit_pipe.sv
// Execution unit with a one-deep registered result channel.
// Logic/shift/add ops complete in one cycle; mul, divu and remu iterate
// one bit per cycle (shift-add / restoring division) for XLEN cycles.
// The last iteration writes the output register directly, so DONE is the
// cycle that presents the result while busy is still high; this gives an
// accept-to-out_valid latency of XLEN+1 with busy high for XLEN+1 cycles.
module exec_unit_pipe #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_opr,
    input  logic [SHW-1:0]  in_shift,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_wra,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_wra,
    output logic            busy
);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd8;
    localparam logic [4:0] OP_OR   = 5'd9;
    localparam logic [4:0] OP_XOR  = 5'd10;
    localparam logic [4:0] OP_NOR  = 5'd11;
    localparam logic [4:0] OP_SLL  = 5'd16;
    localparam logic [4:0] OP_SRL  = 5'd17;
    localparam logic [4:0] OP_SRA  = 5'd18;
    localparam logic [4:0] OP_MUL  = 5'd24;
    localparam logic [4:0] OP_DIVU = 5'd25;
    localparam logic [4:0] OP_REMU = 5'd26;

    localparam logic [SHW:0] LAST = (SHW+1)'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t          state;
    logic [4:0]      opr_q;
    logic [4:0]      wra_q;
    logic [XLEN-1:0] opa;      // multiplier / dividend-quotient shift register
    logic [XLEN-1:0] opb;      // multiplicand / divisor
    logic [XLEN-1:0] acc;      // product / partial remainder
    logic [SHW:0]    cnt;

    logic            accept;
    logic            is_multi;
    logic [XLEN-1:0] alu_res;
    logic [XLEN:0]   div_r;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [XLEN-1:0] nxt_opa;
    logic [XLEN-1:0] nxt_opb;
    logic [XLEN-1:0] nxt_acc;
    logic [XLEN-1:0] fin_res;

    assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_multi = (in_opr == OP_MUL) || (in_opr == OP_DIVU) || (in_opr == OP_REMU);
    assign busy     = (state == ITER) || (state == DONE);

    // Single-cycle result, computed straight from the request operands
    always_comb begin
        alu_res = '1;
        case (in_opr)
            OP_ADD:  alu_res = in_a + in_b;
            OP_SUB:  alu_res = in_a - in_b;
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_NOR:  alu_res = ~(in_a | in_b);
            OP_SLL:  alu_res = in_a << in_shift;
            OP_SRL:  alu_res = in_a >> in_shift;
            OP_SRA:  alu_res = XLEN'($signed(in_a) >>> in_shift);
            default: alu_res = '1;
        endcase
    end

    // One iteration step: shift-add for mul, restoring step for div/rem.
    // A zero divisor naturally yields all-ones quotient and remainder = dividend.
    always_comb begin
        div_r    = {acc, opa[XLEN-1]};
        div_diff = div_r - {1'b0, opb};
        div_ge   = (div_r >= {1'b0, opb});
        if (opr_q == OP_MUL) begin
            nxt_acc = opa[0] ? acc + opb : acc;
            nxt_opa = opa >> 1;
            nxt_opb = opb << 1;
        end else begin
            nxt_acc = div_ge ? div_diff[XLEN-1:0] : div_r[XLEN-1:0];
            nxt_opa = {opa[XLEN-2:0], div_ge};
            nxt_opb = opb;
        end
        fin_res = (opr_q == OP_DIVU) ? nxt_opa : nxt_acc;
    end

    // Control FSM, iteration datapath and registered result channel
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_wra    <= '0;
            cnt        <= '0;
        end else begin
            if (out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_multi) begin
                            state <= ITER;
                            opr_q <= in_opr;
                            wra_q <= in_wra;
                            opa   <= in_a;
                            opb   <= in_b;
                            acc   <= '0;
                            cnt   <= '0;
                        end else begin
                            out_valid  <= 1'b1;
                            out_result <= alu_res;
                            out_wra    <= in_wra;
                        end
                    end
                end
                ITER: begin
                    opa <= nxt_opa;
                    opb <= nxt_opb;
                    acc <= nxt_acc;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state      <= DONE;
                        cnt        <= '0;
                        out_valid  <= 1'b1;
                        out_result <= fin_res;
                        out_wra    <= wra_q;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
